// File: rtl/xor_seq_pkg.sv
// Shared state encoding and channel ids for the XOR ALU sequencer.
package xor_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_RESP  = 2'd3;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int unsigned TMO_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the channel
// that did not win last time.
module rr_arb2
  import xor_seq_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant    = '0;
    grant[0] = valid[0] & (~valid[1] | (last_grant == CH1));
    grant[1] = valid[1] & (~valid[0] | (last_grant == CH0));
  end

endmodule

// File: rtl/xor_alu_sequencer.sv
// Arbitrates two byte requesters onto the shared fixed-key XOR ALU and returns
// each ciphertext, tagged with its channel id, over a valid/ready response port.
module xor_alu_sequencer
  import xor_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  output logic             req1_ready,
  output logic             alu_en,
  output logic [7:0]       alu_data,
  input  logic [7:0]       alu_res,
  input  logic             alu_done,
  output logic             rsp_valid,
  output logic [7:0]       rsp_data,
  output logic             rsp_id,
  output logic             rsp_zero,
  output logic             rsp_err,
  input  logic             rsp_ready,
  output logic             busy,
  output logic [CNT_W-1:0] byte_count
);

  // A zero timeout would never expire; treat it as one cycle.
  localparam int unsigned     TMO_EFF = (TIMEOUT == 0) ? 1 : TIMEOUT;
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_EFF);

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic [1:0]       grant;
  logic             accept;
  logic             acc_id;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept  = (state == S_IDLE) & (|grant);
  assign acc_id  = grant[1] ? CH1 : CH0;
  assign tmo_hit = (tmo_cnt + TMO_W'(1)) == TMO_LIM;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (alu_done || tmo_hit) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    alu_en     = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_en     = (state == S_ISSUE);
    rsp_valid  = (state == S_RESP);
    busy       = (state != S_IDLE);
    req0_ready = (state == S_IDLE) & grant[0];
    req1_ready = (state == S_IDLE) & grant[1];
  end

  // Datapath: operand capture, timeout counting, response capture, byte counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= CH1;
      alu_data   <= '0;
      rsp_id     <= CH0;
      tmo_cnt    <= '0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      byte_count <= '0;
    end else begin
      if (accept) begin
        alu_data   <= grant[1] ? req1_data : req0_data;
        rsp_id     <= acc_id;
        last_grant <= acc_id;
      end
      if (state == S_ISSUE) tmo_cnt <= '0;
      if (state == S_WAIT) begin
        if (alu_done) begin
          rsp_data <= alu_res;
          rsp_zero <= (alu_res == 8'h00);
          rsp_err  <= 1'b0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (tmo_hit) begin
            rsp_data <= 8'h00;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b1;
          end
        end
      end
      if ((state == S_RESP) && rsp_ready && !rsp_err && (byte_count != '1))
        byte_count <= byte_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_xor_alu_sequencer.sv
// Bench for xor_alu_sequencer: a behavioural fixed-key ALU plus a transaction-level
// reference (round-robin winner, ciphertext = byte ^ key, fixed response latency).
module tb_xor_alu_sequencer;

  localparam int unsigned CNT_W = 16;
  localparam logic [7:0]  KEY   = 8'hAA;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0]       req0_data, req1_data;
  logic             alu_en, alu_done;
  logic [7:0]       alu_data, alu_res;
  logic             rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_ready;
  logic [7:0]       rsp_data;
  logic             busy;
  logic [CNT_W-1:0] byte_count;
  logic             stall;

  int          checks = 0;
  int          errors = 0;
  logic        exp_last;
  int unsigned exp_cnt;

  always #5 clk = ~clk;

  xor_alu_sequencer #(.TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .alu_en(alu_en), .alu_data(alu_data), .alu_res(alu_res), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready), .busy(busy), .byte_count(byte_count)
  );

  // Fixed-key ALU: registers the result one cycle after en; stall suppresses done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_done <= 1'b0;
      alu_res  <= 8'h00;
    end else begin
      alu_done <= alu_en & ~stall;
      if (alu_en) alu_res <= alu_data ^ KEY;
    end
  end

  // Stimulus only: offers one byte, reports what it observed (checks live in the tests).
  task automatic run_one(input logic ch, input logic [7:0] d, output logic got,
                         output int en_off, output int en_cnt, output int rsp_off,
                         output logic [7:0] rd, output logic rid, output logic rz,
                         output logic re);
    got = 1'b0; en_off = -1; en_cnt = 0; rsp_off = -1;
    rd = 8'h00; rid = 1'b0; rz = 1'b0; re = 1'b0;
    if (ch) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    for (int k = 0; k < 50; k++) begin
      #1;
      if (ch ? req1_ready : req0_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    exp_last = ch;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      if (alu_en) begin
        en_cnt++;
        if (en_off < 0) en_off = k;
      end
      if (rsp_valid) begin
        rsp_off = k; rd = rsp_data; rid = rsp_id; rz = rsp_zero; re = rsp_err;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_err, alu_en, busy} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h id=%b z=%b e=%b en=%b busy=%b exp all 0",
               rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_err, alu_en, busy);
    end
    checks++;
    if (alu_data !== 8'h00) begin
      errors++; $display("FAIL reset_alu_data got %h exp 00", alu_data);
    end
    checks++;
    if (byte_count !== '0) begin
      errors++; $display("FAIL reset_byte_count got %0d exp 0", byte_count);
    end
    reset = 1'b0; exp_last = 1'b1; exp_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic got, rid, rz, re;
    int en_off, en_cnt, rsp_off;
    logic [7:0] rd, d;
    logic ch;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ch = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      d  = (i == 0) ? 8'h55 : 8'($urandom);
      run_one(ch, d, got, en_off, en_cnt, rsp_off, rd, rid, rz, re);
      if (got && !re) exp_cnt++;
      checks++;
      if (got !== 1'b1) begin errors++; $display("FAIL single_accept[%0d] not accepted", i); end
      checks++;
      if (en_off !== 1 || en_cnt !== 1) begin
        errors++; $display("FAIL single_alu_en[%0d] got off=%0d pulses=%0d exp off=1 pulses=1", i, en_off, en_cnt);
      end
      checks++;
      if (rsp_off !== 3) begin
        errors++; $display("FAIL single_latency[%0d] got %0d exp 3", i, rsp_off);
      end
      checks++;
      if ({rd, rid, rz, re} !== {d ^ KEY, ch, (d ^ KEY) == 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL single_rsp[%0d] got d=%h id=%b z=%b e=%b exp d=%h id=%b z=%b e=0",
                 i, rd, rid, rz, re, d ^ KEY, ch, (d ^ KEY) == 8'h00);
      end
      checks++;
      if (byte_count !== CNT_W'(exp_cnt)) begin
        errors++; $display("FAIL single_count[%0d] got %0d exp %0d", i, byte_count, exp_cnt);
      end
    end
  endtask

  task automatic test_zero();
    logic got, rid, rz, re;
    int en_off, en_cnt, rsp_off;
    logic [7:0] rd;
    rsp_ready = 1'b1;
    run_one(1'b1, 8'hAA, got, en_off, en_cnt, rsp_off, rd, rid, rz, re);
    if (got) exp_cnt++;
    checks++;
    if ({got, rd, rid, rz, re} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL zero_rsp got acc=%b d=%h id=%b z=%b e=%b exp acc=1 d=00 id=1 z=1 e=0",
               got, rd, rid, rz, re);
    end
    checks++;
    if (byte_count !== CNT_W'(exp_cnt)) begin
      errors++; $display("FAIL zero_count got %0d exp %0d", byte_count, exp_cnt);
    end
  endtask

  task automatic test_fairness();
    logic q_id[$];
    logic [7:0] q_d[$];
    logic win, eid;
    logic [7:0] ed;
    int n = 0;
    rsp_ready = 1'b1;
    req0_data = 8'h01; req1_data = 8'h02;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 120 && n < 6; k++) begin
      #1;
      if (req0_ready || req1_ready) begin
        win = ~exp_last;
        checks++;
        if ({req0_ready, req1_ready} !== {~win, win}) begin
          errors++;
          $display("FAIL fair_grant got r0=%b r1=%b exp winner ch%0d", req0_ready, req1_ready, win);
        end
        exp_last = win;
        q_id.push_back(win);
        q_d.push_back((win ? req1_data : req0_data) ^ KEY);
      end
      @(negedge clk);
      if (rsp_valid) begin
        n++;
        eid = (q_id.size() > 0) ? q_id.pop_front() : 1'bx;
        ed  = (q_d.size() > 0) ? q_d.pop_front() : 8'hxx;
        checks++;
        if ({rsp_id, rsp_data} !== {eid, ed}) begin
          errors++;
          $display("FAIL fair_rsp[%0d] got id=%b d=%h exp id=%b d=%h", n, rsp_id, rsp_data, eid, ed);
        end
        exp_cnt++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (n != 6) begin errors++; $display("FAIL fair_timeout got %0d responses exp 6", n); end
    @(negedge clk);
    checks++;
    if (byte_count !== CNT_W'(exp_cnt)) begin
      errors++; $display("FAIL fair_count got %0d exp %0d", byte_count, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic ch, got = 1'b0, seen = 1'b0;
    logic [7:0] d;
    ch = 1'($urandom_range(0, 1));
    d  = 8'($urandom);
    rsp_ready = 1'b0;
    if (ch) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    for (int k = 0; k < 50; k++) begin
      #1;
      if (ch ? req1_ready : req0_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    exp_last = ch;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!(got && seen)) begin errors++; $display("FAIL bp_reach_resp got acc=%b rsp=%b exp 1 1", got, seen); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_err} !==
          {1'b1, d ^ KEY, ch, (d ^ KEY) == 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h id=%b z=%b e=%b exp v=1 d=%h id=%b", k,
                 rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_err, d ^ KEY, ch);
      end
      checks++;
      if ({req0_ready, req1_ready, alu_en} !== 3'b000) begin
        errors++; $display("FAIL bp_quiet[%0d] got r0=%b r1=%b en=%b exp 0 0 0", k, req0_ready, req1_ready, alu_en);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    exp_cnt++;
    @(negedge clk);
    checks++;
    if ({rsp_valid, byte_count} !== {1'b0, CNT_W'(exp_cnt)}) begin
      errors++; $display("FAIL bp_release got v=%b cnt=%0d exp v=0 cnt=%0d", rsp_valid, byte_count, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    logic got, rid, rz, re;
    int en_off, en_cnt, rsp_off;
    logic [7:0] rd;
    stall = 1'b1; rsp_ready = 1'b1;
    run_one(1'b0, 8'($urandom), got, en_off, en_cnt, rsp_off, rd, rid, rz, re);
    stall = 1'b0;
    checks++;
    if (rsp_off !== 10) begin
      errors++; $display("FAIL tmo_latency got %0d exp 10", rsp_off);
    end
    checks++;
    if ({got, rd, rz, re} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
      errors++; $display("FAIL tmo_rsp got acc=%b d=%h z=%b e=%b exp acc=1 d=00 z=0 e=1", got, rd, rz, re);
    end
    checks++;
    if (byte_count !== CNT_W'(exp_cnt)) begin
      errors++; $display("FAIL tmo_count got %0d exp %0d", byte_count, exp_cnt);
    end
  endtask

  task automatic test_reset_wait();
    logic got = 1'b0, seen = 1'b0;
    stall = 1'b1; rsp_ready = 1'b1;
    req1_valid = 1'b1; req1_data = 8'($urandom);
    for (int k = 0; k < 50; k++) begin
      #1;
      if (req1_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({got, busy, rsp_valid} !== 3'b110) begin
      errors++; $display("FAIL rw_in_wait got acc=%b busy=%b v=%b exp 1 1 0", got, busy, rsp_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_err, alu_en, busy, alu_data} !== 22'h0 ||
        byte_count !== '0) begin
      errors++;
      $display("FAIL rw_outputs got v=%b d=%h en=%b busy=%b ad=%h cnt=%0d exp all 0",
               rsp_valid, rsp_data, alu_en, busy, alu_data, byte_count);
    end
    reset = 1'b0; stall = 1'b0; exp_last = 1'b1; exp_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rw_dropped got rsp_valid=1 exp 0"); end
    req0_data = 8'h01; req1_data = 8'h02;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rw_first_grant got r0=%b r1=%b exp 1 0", req0_ready, req1_ready);
    end
    exp_last = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if ({seen, rsp_id, rsp_data} !== {1'b1, 1'b0, 8'h01 ^ KEY}) begin
      errors++; $display("FAIL rw_after got v=%b id=%b d=%h exp v=1 id=0 d=%h", seen, rsp_id, rsp_data, 8'h01 ^ KEY);
    end
    exp_cnt++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic pend = 1'b0, v0, v1, g0, g1, hs, eid = 1'b0, exp_rv;
    logic [7:0] ed = 8'h00;
    int acc_k = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      exp_rv = pend && (k >= acc_k + 3);
      checks++;
      if (rsp_valid !== exp_rv) begin
        errors++; $display("FAIL b2b_valid[%0d] got %b exp %b", k, rsp_valid, exp_rv);
      end
      if (exp_rv) begin
        checks++;
        if ({rsp_data, rsp_id, rsp_err, rsp_zero} !== {ed, eid, 1'b0, ed == 8'h00}) begin
          errors++; $display("FAIL b2b_rsp[%0d] got d=%h id=%b e=%b exp d=%h id=%b", k, rsp_data, rsp_id, rsp_err, ed, eid);
        end
      end
      checks++;
      if (alu_en !== (pend && k == acc_k + 1)) begin
        errors++; $display("FAIL b2b_en[%0d] got %b exp %b", k, alu_en, pend && k == acc_k + 1);
      end
      checks++;
      if (byte_count !== CNT_W'(exp_cnt)) begin
        errors++; $display("FAIL b2b_count[%0d] got %0d exp %0d", k, byte_count, exp_cnt);
      end
      v0 = ($urandom_range(0, 2) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      req0_valid = v0; req1_valid = v1;
      req0_data = 8'($urandom); req1_data = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      hs = exp_rv && rsp_ready;
      g0 = !pend && v0 && (!v1 || exp_last);
      g1 = !pend && v1 && (!v0 || !exp_last);
      checks++;
      if ({req0_ready, req1_ready} !== {g0, g1}) begin
        errors++; $display("FAIL b2b_grant[%0d] got r0=%b r1=%b exp %b %b", k, req0_ready, req1_ready, g0, g1);
      end
      if (g0 || g1) begin
        pend = 1'b1; acc_k = k; eid = g1; exp_last = g1;
        ed = (g1 ? req1_data : req0_data) ^ KEY;
      end
      if (hs) begin pend = 1'b0; exp_cnt++; end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    if (pend) exp_cnt++;
    repeat (8) @(negedge clk);
    checks++;
    if ({busy, byte_count} !== {1'b0, CNT_W'(exp_cnt)}) begin
      errors++; $display("FAIL b2b_drain got busy=%b cnt=%0d exp busy=0 cnt=%0d", busy, byte_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_reset_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
